sha256_w_sched: RTL and testbench

Round sequencer and message-schedule generator for the SHA-256 core. It drives the round index into the K-constant lookup and consumes the returned 32-bit constant. It expands a loaded 512-bit block into W_0..W_63 and streams one (round, W_t, K_t+W_t) beat per round to the compression datapath over a valid/ready handshake.

---
 rtl/sha256_w_sched.sv | 67 ++++++
 tb/tb_sha256_w_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_w_sched.sv
// sha256_w_sched: SHA-256 round sequencer and message-schedule window streaming (t, W_t, K_t+W_t) beats.
module sha256_w_sched (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] block,
  output logic         busy,
  output logic [5:0]   k_idx,
  input  logic [31:0]  k_val,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [5:0]   out_round,
  output logic [31:0]  out_w,
  output logic [31:0]  out_kw,
  output logic         out_last,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [31:0] w [16];
  logic [5:0] round;
  logic [31:0] w_new;
  logic accept;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  assign accept = out_valid & out_ready;
  assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      round <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        round <= '0;
        for (int i = 0; i < 16; i++) w[i] <= block[511 - 32*i -: 32];
      end else if (accept) begin
        // round 63 is terminal and holds; the window still shifts
        round <= (round == 6'd63) ? round : round + 6'd1;
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= w_new;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE && start) state_nxt = RUN;
    else if (state == RUN && accept && round == 6'd63) state_nxt = DONE;
    else if (state == DONE) state_nxt = IDLE;
  end
  assign out_valid = state == RUN;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign k_idx     = round;
  assign out_round = round;
  assign out_w     = w[0];
  assign out_kw    = w[0] + k_val;
  assign out_last  = out_valid && round == 6'd63;
endmodule

// File: tb/tb_sha256_w_sched.sv
// tb_sha256_w_sched: directed self-checking bench for the SHA-256 message schedule streamer.
module tb_sha256_w_sched;
  logic clk = 0, reset, start, out_ready;
  logic [511:0] block;
  logic busy, out_valid, out_last, done;
  logic [5:0] k_idx, out_round;
  logic [31:0] k_val, out_w, out_kw;
  int passed = 0, total = 0;
  logic [31:0] exp_w [64];
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  assign k_val = K[k_idx];
  always #5 clk = ~clk;
  sha256_w_sched dut (.clk(clk), .reset(reset), .start(start), .block(block), .busy(busy), .k_idx(k_idx),
    .k_val(k_val), .out_valid(out_valid), .out_ready(out_ready), .out_round(out_round), .out_w(out_w),
    .out_kw(out_kw), .out_last(out_last), .done(done));
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  task automatic build_model(input logic [511:0] b);
    for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10)) + exp_w[t-7]
               + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3)) + exp_w[t-16];
  endtask
  function automatic logic [511:0] pattern(input logic [31:0] seed);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = seed * (i + 1) ^ {i[7:0], 24'h5a5a5a};
    return b;
  endfunction
  function automatic logic [72:0] beat_exp(input int t);
    return {1'b1, 1'b0, 6'(t), exp_w[t], 32'(exp_w[t] + K[t]), 1'(t == 63)};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [511:0] b);
    block = b;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic test_reset;
    reset = 1; start = 1; block = ABC; out_ready = 0;
    tick(); tick();
    total++;
    if ({out_valid, busy, done, k_idx, out_w} !== 41'b0)
      $display("FAIL reset_outputs: got v=%b b=%b d=%b k=%0d w=%h want all zero", out_valid, busy, done, k_idx, out_w);
    else passed++;
    total++;
    if (out_kw !== K[0]) $display("FAIL reset_kw: got %h want %h", out_kw, K[0]); else passed++;
    reset = 0; start = 0;
    tick(); tick(); tick();
    total++;
    if ({out_valid, busy, done} !== 3'b0)
      $display("FAIL reset_idle_hold: got v=%b b=%b d=%b want 000", out_valid, busy, done);
    else passed++;
  endtask
  task automatic test_abc;
    logic [31:0] kw0, w16, w17;
    build_model(ABC);
    out_ready = 1;
    do_start(ABC);
    for (int t = 0; t < 64; t++) begin
      total++;
      if ({out_valid, done, out_round, out_w, out_kw, out_last} !== beat_exp(t))
        $display("FAIL abc_beat%0d: got r=%0d w=%h kw=%h v=%b l=%b want w=%h kw=%h", t, out_round, out_w, out_kw,
                 out_valid, out_last, exp_w[t], 32'(exp_w[t] + K[t]));
      else passed++;
      if (t == 0) kw0 = out_kw;
      if (t == 16) w16 = out_w;
      if (t == 17) w17 = out_w;
      tick();
    end
    total++;
    if ({done, busy, out_valid} !== 3'b110)
      $display("FAIL abc_done_n65: got d=%b b=%b v=%b want 110", done, busy, out_valid);
    else passed++;
    tick();
    total++;
    if ({done, busy} !== 2'b00) $display("FAIL abc_idle_n66: got d=%b b=%b want 00", done, busy); else passed++;
    total++;
    if (kw0 !== 32'hA3EC9318) $display("FAIL abc_kw0: got %h want a3ec9318", kw0); else passed++;
    total++;
    if (w16 !== 32'h61626380) $display("FAIL abc_w16: got %h want 61626380", w16); else passed++;
    total++;
    if (w17 !== 32'h000F0000) $display("FAIL abc_w17: got %h want 000f0000", w17); else passed++;
  endtask
  task automatic test_zero;
    logic [31:0] kw0, kw63;
    out_ready = 1;
    do_start('0);
    for (int t = 0; t < 64; t++) begin
      total++;
      if ({out_valid, out_round, out_w, out_kw, out_last} !== {1'b1, 6'(t), 32'h0, K[t], 1'(t == 63)})
        $display("FAIL zero_beat%0d: got r=%0d w=%h kw=%h l=%b want kw=%h", t, out_round, out_w, out_kw, out_last, K[t]);
      else passed++;
      if (t == 0) kw0 = out_kw;
      if (t == 63) kw63 = out_kw;
      tick();
    end
    total++;
    if (kw0 !== 32'h428a2f98) $display("FAIL zero_kw0: got %h want 428a2f98", kw0); else passed++;
    total++;
    if (kw63 !== 32'hc67178f2) $display("FAIL zero_kw63: got %h want c67178f2", kw63); else passed++;
    total++;
    if ({done, out_valid, out_last} !== 3'b100) $display("FAIL zero_done: got d=%b v=%b l=%b want 100", done, out_valid, out_last);
    else passed++;
    tick();
  endtask
  task automatic test_backpressure;
    logic [511:0] b;
    int beat, stalls, cyc;
    logic held;
    b = pattern(32'h9e3779b9);
    build_model(b);
    out_ready = 0;
    do_start(b);
    beat = 0; stalls = 0; cyc = 0; held = 0;
    while (beat < 64 && cyc < 2000) begin
      total++;
      if ({out_valid, done, out_round, out_w, out_kw, out_last} !== beat_exp(beat))
        $display("FAIL bp_beat%0d_cyc%0d: got r=%0d w=%h kw=%h v=%b want w=%h", beat, cyc, out_round, out_w, out_kw,
                 out_valid, exp_w[beat]);
      else passed++;
      if ((beat == 0 || beat == 15 || beat == 63) && !held) begin
        out_ready = 0;
        held = 1;
      end else out_ready = 1'($urandom_range(0, 1));
      tick();
      if (out_ready) begin
        beat++;
        held = 0;
      end else stalls++;
      cyc++;
    end
    out_ready = 1;
    total++;
    if (beat != 64) $display("FAIL bp_timeout: got %0d beats want 64", beat); else passed++;
    total++;
    if ({done, out_valid} !== 2'b10) $display("FAIL bp_done: got d=%b v=%b want 10 after %0d stalls", done, out_valid, stalls);
    else passed++;
    tick();
    total++;
    if (done !== 1'b0) $display("FAIL bp_done_pulse: got %b want 0", done); else passed++;
  endtask
  task automatic test_start_busy;
    build_model(ABC);
    out_ready = 1;
    do_start(ABC);
    for (int t = 0; t < 64; t++) begin
      total++;
      if ({out_valid, done, out_round, out_w, out_kw, out_last} !== beat_exp(t))
        $display("FAIL sb_beat%0d: got r=%0d w=%h kw=%h want w=%h", t, out_round, out_w, out_kw, exp_w[t]);
      else passed++;
      if (t == 5 || t == 63) block = {16{32'hffffffff}};
      start = (t == 5 || t == 63);
      tick();
    end
    total++;
    if ({done, out_valid} !== 2'b10) $display("FAIL sb_done: got d=%b v=%b want 10", done, out_valid); else passed++;
    start = 1;
    tick();
    start = 0;
    total++;
    if ({busy, out_valid, done} !== 3'b000) $display("FAIL sb_no_restart: got b=%b v=%b d=%b want 000", busy, out_valid, done);
    else passed++;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL sb_idle_hold: got busy=%b want 0", busy); else passed++;
  endtask
  task automatic test_reset_mid;
    logic [511:0] b;
    b = pattern(32'h7f4a7c15);
    build_model(b);
    out_ready = 1;
    do_start(b);
    for (int t = 0; t <= 30; t++) begin
      total++;
      if ({out_valid, done, out_round, out_w, out_kw, out_last} !== beat_exp(t))
        $display("FAIL rm_pre_beat%0d: got r=%0d w=%h want w=%h", t, out_round, out_w, exp_w[t]);
      else passed++;
      if (t < 30) tick();
    end
    reset = 1;
    tick();
    total++;
    if ({out_valid, busy, done, k_idx, out_w} !== 41'b0)
      $display("FAIL rm_reset: got v=%b b=%b d=%b k=%0d w=%h want zero", out_valid, busy, done, k_idx, out_w);
    else passed++;
    reset = 0;
    tick();
    total++;
    if ({done, busy} !== 2'b00) $display("FAIL rm_no_done: got d=%b b=%b want 00", done, busy); else passed++;
    b = pattern(32'h3c6ef372);
    build_model(b);
    do_start(b);
    for (int t = 0; t < 64; t++) begin
      total++;
      if ({out_valid, done, out_round, out_w, out_kw, out_last} !== beat_exp(t))
        $display("FAIL rm_post_beat%0d: got r=%0d w=%h kw=%h want w=%h", t, out_round, out_w, out_kw, exp_w[t]);
      else passed++;
      tick();
    end
    total++;
    if (done !== 1'b1) $display("FAIL rm_post_done: got %b want 1", done); else passed++;
    tick();
  endtask
  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
